pick_motion_ctrl: RTL and testbench
===================================

Name: pick_motion_ctrl

Overview:
- Player-facing pick controller for the lock-picking levels.
- Converts keyboard keycodes into a vertical pick position (pickY) and the active-low open strobe (openner), advancing once per video frame.
- Sits directly upstream of the per-level pin checkers, which compare the pickY bucket against the random pin and complete when openner is low.
- Guarantees that openner only drops after the pick has been held still with the open key pressed for a set number of frames.

Parameters:
- Y_MIN, 32: lowest legal pickY (top of pin region)
- Y_MAX, 479: highest legal pickY
- Y_INIT, 32: pickY after reset / on level entry
- STEP, 2: pixels moved per frame tick
- HOLD_FRAMES, 30: consecutive qualifying frame ticks required to open (1..63)
- KEY_UP, 8'h1A: keycode for up (W)
- KEY_DOWN, 8'h16: keycode for down (S)
- KEY_OPEN, 8'h2C: keycode for open (space)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  raw vertical-sync frame clock, asynchronous to Clk
- keycode0  in  8  first held key from the USB keyboard, 0 = none
- keycode1  in  8  second held key, 0 = none
- levelActive  in  1  high while a pin level is running
- pickY  out  10  pick vertical position, always within [Y_MIN, Y_MAX]
- openner  out  1  low = open attempt committed; high otherwise
- holdCount  out  6  qualifying frames accumulated so far (debug / HUD bar)
- pickState  out  2  current FSM state encoding (HUD / debug)

Behaviour:
- Reset is synchronous and active-high; clocking is on one clock, Clk. All state updates on posedge Clk.
- Reset values: pickY = Y_INIT, openner = 1, holdCount = 0, FSM = IDLE, sync flops = 0.
- Frame tick: frame_clk passes through 2 synchronizer flops, then rising-edge detection gives a 1-Clk pulse, tick.
  - tick is high on the 3rd Clk edge after frame_clk is first sampled high.
  - Any pickY, holdCount or openner change is visible on the next edge (latency 4 Clk).
- Key decode: up = either keycode equals KEY_UP; down, open likewise. Both up and down asserted is treated as no move.
- Movement on tick, in AIM or HOLD only:
  - Up: pickY = (pickY < Y_MIN+STEP) ? Y_MIN : pickY-STEP.
  - Down: pickY = (pickY > Y_MAX-STEP) ? Y_MAX : pickY+STEP.
  - Arithmetic is unsigned 10-bit, with no wrap-around.
- FSM:
  - IDLE: pickY held at Y_INIT, openner = 1, holdCount = 0. Go to AIM when levelActive = 1.
  - AIM:
    - On tick with open and no move: holdCount = 1, go to HOLD. If HOLD_FRAMES = 1, go straight to OPEN.
    - Otherwise apply movement.
  - HOLD:
    - On tick with open and no move: holdCount += 1. When the new count equals HOLD_FRAMES, go to OPEN.
    - On tick with a move key, or with open released: holdCount = 0, apply movement, go to AIM.
  - OPEN:
    - openner = 0 and pickY is frozen.
    - Any move key, or open released, returns to AIM on the next tick with holdCount = 0 and openner = 1. The movement on that tick is not applied.
- Between ticks nothing changes except the transitions driven by levelActive.
- levelActive falling, from any state, forces IDLE on the next edge: pickY = Y_INIT, openner = 1, holdCount = 0. This takes priority over tick.
- Reset asserted mid-operation, including in OPEN, restores all reset values on that edge. A frame edge in flight is discarded.
- pickState encoding: IDLE = 0, AIM = 1, HOLD = 2, OPEN = 3.

Decomposition:
- Package pick_pkg:
  - State enum pick_state_t (IDLE, AIM, HOLD, OPEN).
  - Key code constants KEY_UP, KEY_DOWN, KEY_OPEN.
  - PICK_Y_MIN and PICK_Y_MAX. The level checkers import the same bounds for bucket decoding.
- One sub-module, frame_tick_sync: 2-flop synchronizer plus rising-edge detector with its own Reset, outputting the tick pulse.

Test Plan:
- Reset then levelActive = 1, keycode0 = 8'h16, 5 frame ticks -> pickY 32 -> 42, openner = 1, pickState = AIM.
- pickY = 34, keycode0 = 8'h1A, 3 ticks -> pickY 32, 32, 32 (clamped). Drive pickY to 478 with down -> next tick 479, then stays 479.
- keycode0 = 8'h2C, no move, 30 ticks -> holdCount 1..29 with openner = 1. On the 30th tick's next edge, openner = 0, pickState = 3 and pickY is unchanged.
- Open held for 20 ticks, then keycode1 = 8'h16 on tick 21 -> holdCount = 0, pickY += 2, AIM. Re-holding needs a full 30 more ticks.
- Up and down held simultaneously, 4 ticks -> pickY unchanged, holdCount = 0. Open plus up -> movement wins, openner stays 1.
- In OPEN, drop levelActive -> next edge IDLE, pickY = 32, openner = 1. Repeat with Reset = 1 instead, same result. Confirm no tick is produced by a frame_clk edge during Reset.

Source files
------------

// File: rtl/pick_pkg.sv
// Shared definitions for the pick controller and the per-level pin checkers.
package pick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AIM  = 2'd1,
    HOLD = 2'd2,
    OPEN = 2'd3
  } pick_state_t;

  localparam logic [7:0] KEY_UP   = 8'h1A;
  localparam logic [7:0] KEY_DOWN = 8'h16;
  localparam logic [7:0] KEY_OPEN = 8'h2C;

  localparam int unsigned PICK_Y_MIN = 32;
  localparam int unsigned PICK_Y_MAX = 479;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vsync frame clock into the Clk domain as a one-cycle tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1, sync2, sync3;

  // tick is registered, so it rises on the third edge after frame_clk is sampled high
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/pick_motion_ctrl.sv
// Keyboard-driven pick position and open strobe, stepped once per video frame.
module pick_motion_ctrl
  import pick_pkg::*;
#(
  parameter int unsigned Y_MIN       = PICK_Y_MIN,
  parameter int unsigned Y_MAX       = PICK_Y_MAX,
  parameter int unsigned Y_INIT      = PICK_Y_MIN,
  parameter int unsigned STEP        = 2,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       levelActive,
  output logic [9:0] pickY,
  output logic       openner,
  output logic [5:0] holdCount,
  output logic [1:0] pickState
);

  localparam logic [9:0] YMIN   = 10'(Y_MIN);
  localparam logic [9:0] YMAX   = 10'(Y_MAX);
  localparam logic [9:0] YINIT  = 10'(Y_INIT);
  localparam logic [9:0] YSTEP  = 10'(STEP);
  localparam logic [5:0] HOLD_N = 6'(HOLD_FRAMES);

  pick_state_t state, state_n;
  logic [9:0]  pick_y, pick_y_n, moved_y;
  logic [5:0]  hold_cnt, hold_cnt_n;
  logic        tick;
  logic        key_up, key_down, key_open;
  logic        mv_up, mv_down, hold_req;

  frame_tick_sync u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  always_comb begin
    key_up   = (keycode0 == KEY_UP)   || (keycode1 == KEY_UP);
    key_down = (keycode0 == KEY_DOWN) || (keycode1 == KEY_DOWN);
    key_open = (keycode0 == KEY_OPEN) || (keycode1 == KEY_OPEN);
    mv_up    = key_up & ~key_down;
    mv_down  = key_down & ~key_up;
    hold_req = key_open & ~mv_up & ~mv_down;
  end

  // Clamp tests are done before the add/subtract so the 10-bit result never wraps
  always_comb begin
    moved_y = pick_y;
    if (mv_up)
      moved_y = (pick_y < YMIN + YSTEP) ? YMIN : pick_y - YSTEP;
    else if (mv_down)
      moved_y = (pick_y > YMAX - YSTEP) ? YMAX : pick_y + YSTEP;
  end

  always_comb begin
    state_n    = state;
    pick_y_n   = pick_y;
    hold_cnt_n = hold_cnt;
    if (!levelActive) begin
      state_n    = IDLE;
      pick_y_n   = YINIT;
      hold_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n    = AIM;
          pick_y_n   = YINIT;
          hold_cnt_n = '0;
        end
        AIM: if (tick) begin
          if (hold_req) begin
            hold_cnt_n = 6'd1;
            state_n    = (HOLD_N == 6'd1) ? OPEN : HOLD;
          end else begin
            pick_y_n = moved_y;
          end
        end
        HOLD: if (tick) begin
          if (hold_req) begin
            hold_cnt_n = hold_cnt + 6'd1;
            if (hold_cnt_n == HOLD_N) state_n = OPEN;
          end else begin
            hold_cnt_n = '0;
            pick_y_n   = moved_y;
            state_n    = AIM;
          end
        end
        OPEN: if (tick && !hold_req) begin
          hold_cnt_n = '0;
          state_n    = AIM;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      pick_y   <= YINIT;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      pick_y   <= pick_y_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    pickY     = pick_y;
    holdCount = hold_cnt;
    openner   = (state != OPEN);
    pickState = state;
  end

endmodule

// File: tb/tb_pick_motion_ctrl.sv
// Directed and randomized checks of pick_motion_ctrl against a behavioural frame model.
module tb_pick_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode0, keycode1;
  logic       levelActive;
  logic [9:0] pickY;
  logic       openner;
  logic [5:0] holdCount;
  logic [1:0] pickState;

  int total = 0;
  int bad   = 0;

  // model: state as 0..3 (idle/aim/hold/open), position and hold count as plain ints
  int my, mhc, mst;

  localparam int YMIN = 32, YMAX = 479, YINIT = 32, STEP = 2, HF = 30;

  pick_motion_ctrl #(.Y_MIN(32), .Y_MAX(479), .Y_INIT(32), .STEP(2), .HOLD_FRAMES(30)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .keycode0(keycode0), .keycode1(keycode1), .levelActive(levelActive),
    .pickY(pickY), .openner(openner), .holdCount(holdCount), .pickState(pickState)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pickY"}, int'(pickY), my);
    check({tag, ".holdCount"}, int'(holdCount), mhc);
    check({tag, ".openner"}, int'(openner), (mst == 3) ? 0 : 1);
    check({tag, ".pickState"}, int'(pickState), mst);
  endtask

  function automatic bit has(input logic [7:0] k);
    return (keycode0 == k) || (keycode1 == k);
  endfunction

  task automatic model_idle();
    mst = 0; my = YINIT; mhc = 0;
  endtask

  task automatic model_tick();
    bit up, dn, op, mup, mdn, hold;
    int ny;
    up = has(8'h1A); dn = has(8'h16); op = has(8'h2C);
    mup = up && !dn; mdn = dn && !up;
    hold = op && !mup && !mdn;
    ny = my;
    if (mup) ny = (my - STEP < YMIN) ? YMIN : my - STEP;
    if (mdn) ny = (my + STEP > YMAX) ? YMAX : my + STEP;
    if (!levelActive) return;
    case (mst)
      1: if (hold) begin mhc = 1; mst = (HF == 1) ? 3 : 2; end else my = ny;
      2: if (hold) begin mhc++; if (mhc == HF) mst = 3; end
         else begin mhc = 0; my = ny; mst = 1; end
      3: if (!hold) begin mhc = 0; mst = 1; end
      default: ;
    endcase
  endtask

  task automatic set_keys(input logic [7:0] k0, input logic [7:0] k1);
    @(negedge Clk);
    keycode0 = k0; keycode1 = k1;
  endtask

  // one frame: outputs must hold through the 3rd edge and update on the 4th
  task automatic frame(input string tag);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 check({tag, ".early"}, int'(pickY), my);
    @(posedge Clk);
    model_tick();
    #1 check_all(tag);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic set_level(input logic v, input string tag);
    @(negedge Clk) levelActive = v;
    @(posedge Clk);
    if (!v) model_idle();
    else if (mst == 0) mst = 1;
    #1 check_all(tag);
  endtask

  initial begin
    logic [7:0] keys [6];
    keys = '{8'h00, 8'h1A, 8'h16, 8'h2C, 8'h2C, 8'h05};
    Reset = 1'b1; frame_clk = 1'b0; keycode0 = '0; keycode1 = '0; levelActive = 1'b0;
    model_idle();
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    @(posedge Clk); #1 check_all("reset");

    set_level(1'b1, "enter");
    set_keys(8'h16, 8'h00);
    for (int unsigned i = 0; i < 5; i++) frame("down5");
    check("down5.final", int'(pickY), 42);
    set_keys(8'h1A, 8'h00);
    for (int unsigned i = 0; i < 8; i++) frame("upclamp");
    check("upclamp.final", int'(pickY), 32);

    set_keys(8'h2C, 8'h00);
    for (int unsigned i = 0; i < HF; i++) frame("hold30");
    check("hold30.openner", int'(openner), 0);
    check("hold30.state", int'(pickState), 3);
    set_keys(8'h00, 8'h00);
    frame("release");

    set_keys(8'h2C, 8'h00);
    for (int unsigned i = 0; i < 20; i++) frame("hold20");
    set_keys(8'h2C, 8'h16);
    frame("interrupt");
    check("interrupt.pickY", int'(pickY), 34);
    set_keys(8'h2C, 8'h00);
    for (int unsigned i = 0; i < 29; i++) frame("rehold");
    check("rehold.openner", int'(openner), 1);
    frame("rehold30");
    check("rehold30.openner", int'(openner), 0);

    set_keys(8'h1A, 8'h16);
    for (int unsigned i = 0; i < 4; i++) frame("updown");
    set_keys(8'h2C, 8'h1A);
    for (int unsigned i = 0; i < 3; i++) frame("openup");
    check("openup.openner", int'(openner), 1);

    set_keys(8'h16, 8'h00);
    for (int unsigned i = 0; i < 230; i++) frame("downclamp");
    check("downclamp.final", int'(pickY), 479);

    for (int unsigned i = 0; i < 150; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        set_level(1'b0, "rnd.drop");
        set_level(1'b1, "rnd.raise");
      end
      set_keys(keys[$urandom_range(0, 5)], keys[$urandom_range(0, 5)]);
      frame("rnd");
    end

    set_keys(8'h00, 8'h2C);
    for (int unsigned i = 0; i < HF + 1; i++) frame("open.lvl");
    set_level(1'b0, "lvldrop");
    set_level(1'b1, "lvlraise");

    set_keys(8'h2C, 8'h00);
    for (int unsigned i = 0; i < HF; i++) frame("open.rst");
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    model_idle();
    #1 check_all("midreset");
    set_keys(8'h16, 8'h00);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    mst = 1;
    #1 check_all("postreset");
    repeat (8) @(posedge Clk);
    #1 check_all("noghost");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
